// File: rtl/control_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_word_sequencer
//  Brief    : Loadable micro-program sequencer issuing datapath control words
//             and constants, with Z-flag branching and single-step support.
//  Revision : 1.0  initial release
// ============================================================================
module control_word_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              Z,
    output logic [15:0]       control_word,
    output logic [7:0]        constant_out,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        issue_count
);

    localparam int         c_depth    = 2**ADDR_W;
    localparam logic [1:0] c_seq_next = 2'b00;
    localparam logic [1:0] c_seq_jump = 2'b01;
    localparam logic [1:0] c_seq_brz  = 2'b10;
    localparam logic [1:0] c_seq_halt = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            r_state;
    logic [31:0]       r_mem [c_depth];
    logic [15:0]       r_cw;
    logic [7:0]        r_const;
    logic [ADDR_W-1:0] r_pc;
    logic              r_busy;
    logic              r_halted;
    logic [7:0]        r_count;

    logic [31:0]       w_entry;
    logic [1:0]        w_seq;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_advance;

    // Program memory: no reset, so a loaded program survives a sequencer reset.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state != ST_RUN)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign w_entry   = r_mem[r_pc];
    assign w_seq     = w_entry[31:30];
    assign w_target  = w_entry[24 +: ADDR_W];
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_advance = (r_state == ST_RUN) && (!step_mode || step);

    // TARGET field is 6 bits wide; bits above ADDR_W carry no meaning.
    if (ADDR_W < 6) begin : g_target_pad
        logic w_unused_target;
        assign w_unused_target = ^w_entry[29:24+ADDR_W];
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_seq)
            c_seq_jump: w_pc_next = w_target;
            c_seq_brz:  w_pc_next = Z ? w_target : w_pc_inc;
            c_seq_halt: w_pc_next = r_pc;
            default:    w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cw     <= 16'h0000;
            r_const  <= 8'h00;
            r_pc     <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_count  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_pc     <= '0;
                        r_count  <= 8'h00;
                        r_halted <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        if (w_seq == c_seq_halt) begin
                            r_cw     <= 16'h0000;
                            r_const  <= 8'h00;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else begin
                            r_cw    <= w_entry[15:0];
                            r_const <= w_entry[23:16];
                            r_pc    <= w_pc_next;
                            if (r_count != 8'hFF) begin
                                r_count <= r_count + 8'd1;
                            end
                        end
                    end else begin
                        // Hold the word but drop RW so the datapath never writes twice.
                        r_cw[0] <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign control_word = r_cw;
    assign constant_out = r_const;
    assign pc           = r_pc;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign issue_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_control_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_word_sequencer
//  Brief    : Scoreboard bench with a program-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_word_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, step_mode, step, prog_we, Z;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
    logic [15:0] control_word;
    logic [7:0]  constant_out;
    logic [3:0]  pc;
    logic        busy, halted;
    logic [7:0]  issue_count;

    always #5 clk = ~clk;

    control_word_sequencer #(.ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .step_mode    (step_mode),
        .step         (step),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .Z            (Z),
        .control_word (control_word),
        .constant_out (constant_out),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .issue_count  (issue_count)
    );

    // Datapath stand-in: Z is a fixed function of the presented word.
    function automatic bit zf(input logic [15:0] w);
        return (w[15:13] == 3'b000);
    endfunction
    assign Z = zf(control_word);

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  k;
        logic [3:0]  pc;
        logic        busy;
        logic        halted;
        logic [7:0]  cnt;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    done   = 0;

    // Reference model: 0 idle, 1 run, 2 halt
    logic [31:0] m_mem [16];
    int          m_mode;
    logic [15:0] m_cw;
    logic [7:0]  m_k;
    logic [3:0]  m_pc;
    logic [7:0]  m_cnt;

    task automatic model_edge(input bit rs, input bit st, input bit we,
                              input logic [3:0] wa, input logic [31:0] wd,
                              input bit sm, input bit stp, output snap_t s);
        bit          z;
        logic [31:0] e;
        z = zf(m_cw);
        e = m_mem[m_pc];
        if (rs) begin
            m_mode = 0; m_cw = 0; m_k = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode != 1) begin
            if (we) m_mem[wa] = wd;
            if (st) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
            end
        end else if (!sm || stp) begin
            if (e[31:30] == 2'b11) begin
                m_mode = 2; m_cw = 0; m_k = 0;
            end else begin
                m_cw  = e[15:0];
                m_k   = e[23:16];
                m_cnt = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
                if (e[31:30] == 2'b01 || (e[31:30] == 2'b10 && z)) m_pc = e[27:24];
                else m_pc = m_pc + 4'd1;
            end
        end else begin
            m_cw[0] = 1'b0;
        end
        s = '{m_cw, m_k, m_pc, (m_mode == 1), (m_mode == 2), m_cnt};
    endtask

    task automatic cycle(input bit rs, input bit st, input bit we,
                         input logic [3:0] wa, input logic [31:0] wd,
                         input bit sm, input bit stp);
        snap_t s;
        reset = rs; start = st; prog_we = we; prog_addr = wa; prog_data = wd;
        step_mode = sm; step = stp;
        model_edge(rs, st, we, wa, wd, sm, stp, s);
        @(posedge clk);
        exp_q.push_back(s);
        #1;
    endtask

    task automatic idle_cyc(input int n, input bit sm);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'd0, 32'd0, sm, 0);
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        cycle(0, 0, 1, a, d, 0, 0);
    endtask

    function automatic logic [31:0] ent(input logic [1:0] sq, input logic [5:0] tg,
                                        input logic [7:0] k, input logic [15:0] cw);
        return {sq, tg, k, cw};
    endfunction

    // Monitor: compares every presented output sample against the scoreboard.
    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (control_word !== e.cw || constant_out !== e.k || pc !== e.pc ||
                busy !== e.busy || halted !== e.halted || issue_count !== e.cnt) begin
                errors++;
                $display("FAIL outputs t=%0t got cw=%h k=%h pc=%0d busy=%b halted=%b cnt=%0d want cw=%h k=%h pc=%0d busy=%b halted=%b cnt=%0d",
                         $time, control_word, constant_out, pc, busy, halted, issue_count,
                         e.cw, e.k, e.pc, e.busy, e.halted, e.cnt);
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d pending want 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 0);
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 0);
        idle_cyc(2, 0);

        // Linear: one issue then halt
        load(4'd0, ent(2'b00, 6'd0, 8'h05, 16'h1234));
        load(4'd1, ent(2'b11, 6'd0, 8'hFF, 16'hFFFF));
        cycle(0, 1, 0, 4'd0, 32'd0, 0, 0);
        idle_cyc(5, 0);

        // Branch taken (mem0 word yields Z=1): mem1 jumps to mem3
        load(4'd0, ent(2'b00, 6'd0, 8'h11, 16'h0103));
        load(4'd1, ent(2'b10, 6'd3, 8'h22, 16'h4441));
        load(4'd2, ent(2'b01, 6'd4, 8'h33, 16'h5555));
        load(4'd3, ent(2'b00, 6'd0, 8'h44, 16'hABCD));
        load(4'd4, ent(2'b11, 6'd0, 8'h00, 16'h0000));
        cycle(0, 1, 0, 4'd0, 32'd0, 0, 0);
        idle_cyc(7, 0);
        // Branch not taken (mem0 word yields Z=0), also start+write on same edge
        cycle(0, 1, 1, 4'd0, ent(2'b00, 6'd0, 8'h12, 16'hE103), 0, 0);
        idle_cyc(7, 0);

        // Step mode: pulses at cycles 5 and 9 after start
        load(4'd0, ent(2'b00, 6'd0, 8'hA1, 16'h2001));
        load(4'd1, ent(2'b00, 6'd0, 8'hA2, 16'h3003));
        load(4'd2, ent(2'b00, 6'd0, 8'hA3, 16'h4005));
        load(4'd3, ent(2'b11, 6'd0, 8'h00, 16'h0000));
        cycle(0, 1, 0, 4'd0, 32'd0, 1, 0);
        for (int c = 1; c <= 14; c++) cycle(0, 0, 0, 4'd0, 32'd0, 1, (c == 5 || c == 9));

        // Reset mid-run, then restart: program must still be there
        cycle(1, 0, 0, 4'd0, 32'd0, 1, 0);
        idle_cyc(2, 1);
        cycle(0, 1, 0, 4'd0, 32'd0, 1, 0);
        for (int c = 1; c <= 8; c++) cycle(0, 0, 0, 4'd0, 32'd0, 1, (c == 2 || c == 5));
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 0);

        // Wrap and saturation, with ignored writes/starts during RUN
        for (int a = 0; a < 16; a++)
            load(4'(a), ent(2'b00, 6'($urandom), 8'(a * 3), 16'($urandom) | 16'h0001));
        cycle(0, 1, 0, 4'd0, 32'd0, 0, 0);
        for (int c = 0; c < 300; c++)
            cycle(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                  4'($urandom), $urandom, 0, 0);
        cycle(1, 0, 0, 4'd0, 32'd0, 0, 0);

        // Randomized programs, modes, steps and noise
        for (int r = 0; r < 12; r++) begin
            bit sm;
            sm = ($urandom_range(0, 1) == 1);
            cycle(1, 0, 0, 4'd0, 32'd0, 0, 0);
            for (int a = 0; a < 16; a++) begin
                int  p;
                logic [1:0] sq;
                p  = $urandom_range(0, 9);
                sq = (p < 6) ? 2'b00 : (p == 6) ? 2'b01 : (p < 9) ? 2'b10 : 2'b11;
                load(4'(a), ent(sq, 6'($urandom), 8'($urandom), 16'($urandom)));
            end
            cycle(0, 1, 0, 4'd0, 32'd0, sm, 0);
            for (int c = 0; c < 80; c++)
                cycle(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                      4'($urandom), $urandom, sm, ($urandom_range(0, 2) == 0));
        end

        done = 1;
    end

endmodule
`default_nettype wire
